// File: rtl/associate_pkg.sv
// Shared types and constants for the associate neuron trainer.
// Sample word layout is {target[15:0], args[8*N-1:0]}.
package associate_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ARG,
        S_RES,
        S_OUT,
        S_ERR,
        S_FBK,
        S_NEXT,
        S_DONE
    } state_e;

    localparam logic signed [15:0] SAT16_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT16_MIN = 16'sh8000;
    localparam int                 LOSS_W    = 24;
    localparam int                 ARG_LSB   = 0;
    localparam int                 TGT_W     = 16;

    function automatic int tgt_lsb(input int n);
        return 8 * n;
    endfunction

endpackage

// File: rtl/sat_sub16.sv
// Combinational a - b on 16-bit signed operands, clamped to the 16-bit range,
// plus the magnitude of the clamped result (-32768 maps to 16'h8000).
module sat_sub16
    import associate_pkg::*;
(
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic signed [15:0] o_diff,
    output logic        [15:0] o_abs
);

    logic signed [16:0] w_wide;
    logic               w_ovf;

    assign w_wide = {i_a[15], i_a} - {i_b[15], i_b};
    // top two bits disagree only when the 17-bit result leaves the 16-bit range
    assign w_ovf  = w_wide[16] ^ w_wide[15];
    assign o_diff = w_ovf ? (w_wide[16] ? SAT16_MIN : SAT16_MAX) : w_wide[15:0];
    assign o_abs  = o_diff[15] ? ((~o_diff) + 16'd1) : o_diff;

endmodule

// File: rtl/associate_trainer.sv
// Sequencer feeding samples to one associate neuron for inference or online
// training; tracks epochs and per-epoch absolute-error loss.
module associate_trainer
    import associate_pkg::*;
#(
    parameter int N      = 2,
    parameter int EPOCHS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_train,
    output logic                o_busy,
    output logic                o_done,
    output logic [LOSS_W-1:0]   o_loss,
    output logic [15:0]         o_epoch,
    input  logic                i_smp_stb,
    output logic                o_smp_rdy,
    input  logic [8*N+15:0]     i_smp_dat,
    input  logic                i_smp_lst,
    output logic                o_arg_stb,
    input  logic                i_arg_rdy,
    output logic [8*N-1:0]      o_arg_dat,
    input  logic                i_res_stb,
    output logic                o_res_rdy,
    input  logic [15:0]         i_res_dat,
    output logic                o_err_stb,
    input  logic                i_err_rdy,
    output logic [15:0]         o_err_dat,
    input  logic                i_fbk_stb,
    output logic                o_fbk_rdy,
    input  logic [16*N-1:0]     i_fbk_dat,
    output logic                o_en,
    output logic                o_out_stb,
    input  logic                i_out_rdy,
    output logic [15:0]         o_out_dat
);

    localparam int TGT_LSB = tgt_lsb(N);

    state_e                r_state, w_next;
    logic signed [15:0]    r_tgt;
    logic                  r_lst;
    logic [15:0]           r_abs;
    logic [LOSS_W-1:0]     r_acc, r_loss;
    logic [15:0]           r_epoch;
    logic                  r_en;
    logic                  r_arg_stb, r_err_stb, r_out_stb;
    logic [8*N-1:0]        r_arg_dat;
    logic [15:0]           r_err_dat, r_out_dat;

    logic                  w_smp_hs, w_arg_hs, w_res_hs, w_err_hs, w_fbk_hs, w_out_hs;
    logic signed [15:0]    w_diff;
    logic [15:0]           w_abs;
    logic [LOSS_W:0]       w_sum;
    logic [LOSS_W-1:0]     w_acc_sat;
    logic [15:0]           w_epoch_inc;
    logic                  w_last_ep;
    logic                  w_unused;

    // feedback is drained but carries nothing this block needs
    assign w_unused = ^i_fbk_dat;

    assign w_smp_hs = (r_state == S_FETCH) && i_smp_stb;
    assign w_arg_hs = r_arg_stb && i_arg_rdy;
    assign w_res_hs = (r_state == S_RES) && i_res_stb;
    assign w_err_hs = r_err_stb && i_err_rdy;
    assign w_fbk_hs = (r_state == S_FBK) && i_fbk_stb;
    assign w_out_hs = r_out_stb && i_out_rdy;

    sat_sub16 u_sub (
        .i_a    (r_tgt),
        .i_b    (i_res_dat),
        .o_diff (w_diff),
        .o_abs  (w_abs)
    );

    assign w_sum       = {1'b0, r_acc} + {{(LOSS_W-16+1){1'b0}}, r_abs};
    assign w_acc_sat   = w_sum[LOSS_W] ? {LOSS_W{1'b1}} : w_sum[LOSS_W-1:0];
    assign w_epoch_inc = r_epoch + 16'd1;
    assign w_last_ep   = (w_epoch_inc == 16'(EPOCHS));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start)  w_next = S_FETCH;
            S_FETCH: if (w_smp_hs) w_next = S_ARG;
            S_ARG:   if (w_arg_hs) w_next = S_RES;
            S_RES:   if (w_res_hs) w_next = r_en ? S_ERR : S_OUT;
            S_OUT:   if (w_out_hs) w_next = S_NEXT;
            S_ERR:   if (w_err_hs) w_next = S_FBK;
            S_FBK:   if (w_fbk_hs) w_next = S_NEXT;
            S_NEXT: begin
                if (r_lst && (!r_en || w_last_ep)) w_next = S_DONE;
                else                               w_next = S_FETCH;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tgt     <= '0;
            r_lst     <= 1'b0;
            r_abs     <= '0;
            r_acc     <= '0;
            r_loss    <= '0;
            r_epoch   <= '0;
            r_en      <= 1'b0;
            r_arg_stb <= 1'b0;
            r_err_stb <= 1'b0;
            r_out_stb <= 1'b0;
            r_arg_dat <= '0;
            r_err_dat <= '0;
            r_out_dat <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_en    <= i_train;
                r_epoch <= '0;
                r_acc   <= '0;
            end
            if (w_smp_hs) begin
                r_arg_dat <= i_smp_dat[ARG_LSB +: 8*N];
                r_tgt     <= i_smp_dat[TGT_LSB +: TGT_W];
                r_lst     <= i_smp_lst;
                r_arg_stb <= 1'b1;
            end else if (w_arg_hs) begin
                r_arg_stb <= 1'b0;
            end
            // magnitude is kept so inference runs still report loss
            if (w_res_hs) begin
                r_abs <= w_abs;
                if (r_en) begin
                    r_err_stb <= 1'b1;
                    r_err_dat <= w_diff;
                end else begin
                    r_out_stb <= 1'b1;
                    r_out_dat <= i_res_dat;
                end
            end
            if (w_err_hs) r_err_stb <= 1'b0;
            if (w_out_hs) r_out_stb <= 1'b0;
            if (w_err_hs || w_out_hs) r_acc <= w_acc_sat;
            if (r_state == S_NEXT && r_lst) begin
                r_epoch <= w_epoch_inc;
                r_loss  <= r_acc;
                r_acc   <= '0;
            end
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_smp_rdy = (r_state == S_FETCH);
    assign o_res_rdy = (r_state == S_RES);
    assign o_fbk_rdy = (r_state == S_FBK);
    assign o_loss    = r_loss;
    assign o_epoch   = r_epoch;
    assign o_en      = r_en;
    assign o_arg_stb = r_arg_stb;
    assign o_arg_dat = r_arg_dat;
    assign o_err_stb = r_err_stb;
    assign o_err_dat = r_err_dat;
    assign o_out_stb = r_out_stb;
    assign o_out_dat = r_out_dat;

endmodule

// File: tb/tb_associate_trainer.sv
// Randomized bench for associate_trainer: sample source and neuron stub with
// configurable wait states, checked against a transaction-level model.
module tb_associate_trainer;
    localparam int N  = 2;
    localparam int EP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start, i_train;
    logic o_busy, o_done;
    logic [23:0] o_loss;
    logic [15:0] o_epoch;
    logic i_smp_stb, o_smp_rdy, i_smp_lst;
    logic [8*N+15:0] i_smp_dat;
    logic o_arg_stb, i_arg_rdy;
    logic [8*N-1:0] o_arg_dat;
    logic i_res_stb, o_res_rdy;
    logic [15:0] i_res_dat;
    logic o_err_stb, i_err_rdy;
    logic [15:0] o_err_dat;
    logic i_fbk_stb, o_fbk_rdy;
    logic [16*N-1:0] i_fbk_dat;
    logic o_en;
    logic o_out_stb, i_out_rdy;
    logic [15:0] o_out_dat;

    associate_trainer #(.N(N), .EPOCHS(EP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_train(i_train),
        .o_busy(o_busy), .o_done(o_done), .o_loss(o_loss), .o_epoch(o_epoch),
        .i_smp_stb(i_smp_stb), .o_smp_rdy(o_smp_rdy), .i_smp_dat(i_smp_dat), .i_smp_lst(i_smp_lst),
        .o_arg_stb(o_arg_stb), .i_arg_rdy(i_arg_rdy), .o_arg_dat(o_arg_dat),
        .i_res_stb(i_res_stb), .o_res_rdy(o_res_rdy), .i_res_dat(i_res_dat),
        .o_err_stb(o_err_stb), .i_err_rdy(i_err_rdy), .o_err_dat(o_err_dat),
        .i_fbk_stb(i_fbk_stb), .o_fbk_rdy(o_fbk_rdy), .i_fbk_dat(i_fbk_dat),
        .o_en(o_en),
        .o_out_stb(o_out_stb), .i_out_rdy(i_out_rdy), .o_out_dat(o_out_dat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // dataset and model
    logic [15:0] ds_arg[8], ds_tgt[8], ds_res[8];
    int ds_n;
    logic [15:0] exp_arg[$], exp_err[$], exp_out[$];
    int exp_eploss[$];
    int exp_epoch, exp_loss, exp_smp;
    bit run_trn;

    task automatic build_model(input bit trn);
        int e_runs, acc, d;
        e_runs = trn ? EP : 1;
        exp_arg.delete(); exp_err.delete(); exp_out.delete(); exp_eploss.delete();
        for (int e = 0; e < e_runs; e++) begin
            acc = 0;
            for (int s = 0; s < ds_n; s++) begin
                d = int'($signed(ds_tgt[s])) - int'($signed(ds_res[s]));
                if (d > 32767) d = 32767;
                if (d < -32768) d = -32768;
                exp_arg.push_back(ds_arg[s]);
                if (trn) exp_err.push_back(16'(d));
                else     exp_out.push_back(ds_res[s]);
                acc += (d < 0) ? -d : d;
                if (acc > 24'hFFFFFF) acc = 24'hFFFFFF;
            end
            exp_eploss.push_back(acc);
        end
        exp_epoch = e_runs;
        exp_loss  = exp_eploss[e_runs-1];
        exp_smp   = e_runs * ds_n;
    endtask

    task automatic rand_data(input int n);
        ds_n = n;
        for (int s = 0; s < n; s++) begin
            ds_arg[s] = 16'($urandom);
            ds_tgt[s] = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       ds_res[s] = 16'h8000;
                1:       ds_res[s] = 16'h7FFF;
                default: ds_res[s] = 16'($urandom);
            endcase
        end
    endtask

    // peer state (source, neuron stub, sinks)
    int bp = 0;
    int src_left = 0, src_idx = 0, stub_k = 0;
    int arg_cnt, arg_dly, err_cnt, err_dly, out_cnt, out_dly;
    int res_cnt, res_dly, fbk_cnt, fbk_dly;
    bit res_pend, fbk_pend;
    logic [15:0] res_val;
    bit h_smp, h_arg, h_res, h_err, h_fbk, h_out, s_arg, s_err, s_out;

    function automatic int pick();
        if (bp == 0) return 0;
        if (bp == 1) return $urandom_range(0, 5);
        return 5;
    endfunction

    initial begin
        i_start = 0; i_train = 0; i_smp_stb = 0; i_smp_dat = '0; i_smp_lst = 0;
        i_arg_rdy = 0; i_res_stb = 0; i_res_dat = '0; i_err_rdy = 0;
        i_fbk_stb = 0; i_fbk_dat = '0; i_out_rdy = 0;
        arg_cnt = 0; arg_dly = 0; err_cnt = 0; err_dly = 0; out_cnt = 0; out_dly = 0;
        res_cnt = 0; res_dly = 0; fbk_cnt = 0; fbk_dly = 0; res_pend = 0; fbk_pend = 0;
        res_val = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                i_smp_stb = 0; i_arg_rdy = 0; i_res_stb = 0; i_err_rdy = 0;
                i_fbk_stb = 0; i_out_rdy = 0;
                res_pend = 0; fbk_pend = 0; arg_cnt = 0; err_cnt = 0; out_cnt = 0;
                src_idx = 0; stub_k = 0;
                continue;
            end
            if (h_smp) begin
                src_left--;
                src_idx = (src_idx + 1 == ds_n) ? 0 : src_idx + 1;
            end
            i_smp_stb = (src_left > 0);
            i_smp_dat = {ds_tgt[src_idx], ds_arg[src_idx]};
            i_smp_lst = (src_idx == ds_n - 1);
            if (h_arg) begin
                arg_cnt = 0; arg_dly = pick();
                res_pend = 1; res_cnt = 0; res_dly = pick();
                res_val = ds_res[stub_k];
                stub_k = (stub_k + 1 == ds_n) ? 0 : stub_k + 1;
            end else if (s_arg) arg_cnt++;
            i_arg_rdy = (arg_cnt >= arg_dly);
            if (h_res) res_pend = 0;
            if (res_pend && res_cnt >= res_dly) begin
                i_res_stb = 1; i_res_dat = res_val;
            end else begin
                i_res_stb = 0;
                if (res_pend) res_cnt++;
            end
            if (h_err) begin
                err_cnt = 0; err_dly = pick();
                fbk_pend = 1; fbk_cnt = 0; fbk_dly = pick();
            end else if (s_err) err_cnt++;
            i_err_rdy = (err_cnt >= err_dly);
            if (h_fbk) fbk_pend = 0;
            if (fbk_pend && fbk_cnt >= fbk_dly) begin
                i_fbk_stb = 1; i_fbk_dat = 32'($urandom);
            end else begin
                i_fbk_stb = 0;
                if (fbk_pend) fbk_cnt++;
            end
            if (h_out) begin out_cnt = 0; out_dly = pick(); end
            else if (s_out) out_cnt++;
            i_out_rdy = (out_cnt >= out_dly);
        end
    end

    // compare process: every negedge, DUT outputs against the model
    int smp_cnt = 0, done_cnt = 0, busy_cyc = 0;
    logic p_arg_stb, p_err_stb, p_out_stb, p_busy, p_h_arg, p_h_err, p_h_out;
    logic [15:0] p_arg_dat, p_err_dat, p_out_dat, p_epoch;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                {h_smp, h_arg, h_res, h_err, h_fbk, h_out, s_arg, s_err, s_out} = '0;
                p_arg_stb = 0; p_err_stb = 0; p_out_stb = 0; p_busy = 0;
                p_h_arg = 0; p_h_err = 0; p_h_out = 0; p_epoch = '0;
                continue;
            end
            h_smp = i_smp_stb && o_smp_rdy;
            h_arg = o_arg_stb && i_arg_rdy;
            h_res = i_res_stb && o_res_rdy;
            h_err = o_err_stb && i_err_rdy;
            h_fbk = i_fbk_stb && o_fbk_rdy;
            h_out = o_out_stb && i_out_rdy;
            s_arg = o_arg_stb; s_err = o_err_stb; s_out = o_out_stb;
            if (h_smp) smp_cnt++;
            if (o_busy && !o_done) busy_cyc++;
            if (o_busy) chk("en_run", o_en, run_trn);
            if (p_arg_stb && !p_h_arg) chk("arg_hold", {o_arg_stb, o_arg_dat}, {1'b1, p_arg_dat});
            if (p_err_stb && !p_h_err) chk("err_hold", {o_err_stb, o_err_dat}, {1'b1, p_err_dat});
            if (p_out_stb && !p_h_out) chk("out_hold", {o_out_stb, o_out_dat}, {1'b1, p_out_dat});
            if (o_arg_stb) begin
                if (exp_arg.size() == 0) chk("arg_extra", 1, 0);
                else begin
                    chk("arg_dat", o_arg_dat, exp_arg[0]);
                    if (h_arg) void'(exp_arg.pop_front());
                end
            end
            if (o_err_stb) begin
                if (exp_err.size() == 0) chk("err_extra", 1, 0);
                else begin
                    chk("err_dat", o_err_dat, exp_err[0]);
                    if (h_err) void'(exp_err.pop_front());
                end
            end
            if (o_out_stb) begin
                if (exp_out.size() == 0) chk("out_extra", 1, 0);
                else begin
                    chk("out_dat", o_out_dat, exp_out[0]);
                    if (h_out) void'(exp_out.pop_front());
                end
            end
            if (o_busy && p_busy && o_epoch != p_epoch) begin
                chk("epoch_step", o_epoch, p_epoch + 16'd1);
                if (o_epoch >= 1 && int'(o_epoch) <= exp_eploss.size())
                    chk("epoch_loss", o_loss, exp_eploss[o_epoch-1]);
            end
            if (o_done) begin
                done_cnt++;
                chk("done_epoch", o_epoch, exp_epoch);
                chk("done_loss", o_loss, exp_loss);
            end
            p_arg_stb = o_arg_stb; p_arg_dat = o_arg_dat; p_h_arg = h_arg;
            p_err_stb = o_err_stb; p_err_dat = o_err_dat; p_h_err = h_err;
            p_out_stb = o_out_stb; p_out_dat = o_out_dat; p_h_out = h_out;
            p_busy = o_busy; p_epoch = o_epoch;
        end
    end

    task automatic start_run(input bit trn, input int mode);
        @(negedge clk);
        bp = mode;
        arg_dly = pick(); err_dly = pick(); out_dly = pick();
        arg_cnt = 0; err_cnt = 0; out_cnt = 0;
        run_trn = trn; smp_cnt = 0; done_cnt = 0; busy_cyc = 0;
        src_idx = 0; stub_k = 0; src_left = exp_smp;
        @(posedge clk); #1;
        i_start = 1; i_train = trn;
        @(negedge clk);
        chk("rdy_in_idle", o_smp_rdy, 0);
        @(posedge clk); #1;
        i_start = 0; i_train = !trn;
        @(negedge clk);
        chk("start_to_rdy", o_smp_rdy, 1);
    endtask

    task automatic wait_done(input bit disturb);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            if (disturb) begin i_start = 1'($urandom); i_train = 1'($urandom); end
            @(negedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        i_start = 0; i_train = 0;
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("smp_count", smp_cnt, exp_smp);
        chk("idle_busy", o_busy, 0);
        chk("q_empty", exp_arg.size() + exp_err.size() + exp_out.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_busy", o_busy, 0);      chk("rst_done", o_done, 0);
        chk("rst_en", o_en, 0);          chk("rst_loss", o_loss, 0);
        chk("rst_epoch", o_epoch, 0);    chk("rst_smp_rdy", o_smp_rdy, 0);
        chk("rst_stbs", {o_arg_stb, o_err_stb, o_out_stb, o_res_rdy, o_fbk_rdy}, 0);
        chk("rst_dats", {o_arg_dat, o_err_dat}, 0);
        chk("rst_out_dat", o_out_dat, 0);

        // inference, one sample
        ds_n = 1; ds_arg[0] = 16'h2010; ds_tgt[0] = 16'h0000; ds_res[0] = 16'h0005;
        build_model(0);
        chk("pin_arg0", exp_arg[0], 16'h2010);
        chk("pin_out0", exp_out[0], 16'h0005);
        start_run(0, 0); wait_done(0);
        chk("inf_loss", o_loss, 5); chk("inf_epoch", o_epoch, 1);
        chk("inf_cycles", busy_cyc, 5);

        // training, two samples, two epochs
        ds_n = 2; ds_arg[0] = 16'h0102; ds_arg[1] = 16'h0304;
        ds_tgt[0] = 16'd0; ds_tgt[1] = 16'd10; ds_res[0] = 16'hFFFD; ds_res[1] = 16'd4;
        build_model(1);
        chk("pin_err", {exp_err[0][7:0], exp_err[1][7:0], exp_err[2][7:0], exp_err[3][7:0]}, 32'h03060306);
        start_run(1, 0); wait_done(0);
        chk("trn_loss", o_loss, 9); chk("trn_epoch", o_epoch, 2); chk("trn_en", o_en, 1);
        chk("trn_cycles", busy_cyc, 24);

        // saturation both ways
        ds_n = 2; ds_arg[0] = 16'hAA55; ds_arg[1] = 16'h55AA;
        ds_tgt[0] = 16'h7FFF; ds_res[0] = 16'h8000; ds_tgt[1] = 16'h8000; ds_res[1] = 16'h7FFF;
        build_model(1);
        chk("pin_sat", {exp_err[0], exp_err[1]}, 32'h7FFF8000);
        start_run(1, 0); wait_done(0);
        chk("sat_loss", o_loss, 65535);

        // fixed 5-cycle backpressure
        rand_data(3); build_model(1);
        start_run(1, 2); wait_done(0);

        // random data, random waits, both modes
        for (int r = 0; r < 6; r++) begin
            rand_data($urandom_range(1, 6));
            build_model(r[0]);
            start_run(r[0], 1); wait_done(0);
        end

        // start and train wiggled mid-run
        rand_data(3); build_model(1);
        start_run(1, 0); wait_done(1);
        chk("dist_cycles", busy_cyc, 6 * exp_smp);

        // reset while an error is pending
        rand_data(2); build_model(1);
        start_run(1, 2);
        begin
            int cyc = 0;
            while (!o_err_stb && cyc < 300) begin @(negedge clk); cyc++; end
            if (!o_err_stb) chk("reach_err", 0, 1);
        end
        #1 rst_n = 0;
        #1;
        chk("mid_rst_err_stb", o_err_stb, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_en", o_en, 0);
        exp_arg.delete(); exp_err.delete(); exp_out.delete(); src_left = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_idle", o_busy, 0);
        rand_data(2); build_model(1);
        start_run(1, 0); wait_done(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
